// File: rtl/spi_pkg.sv
// Shared constants and FSM state encoding for the byte-oriented SPI master.
package spi_pkg;

    localparam int SPI_BYTE_W          = 8;
    localparam int SPI_MIN_HALF_PERIOD = 4;

    typedef logic [2:0] spi_state_t;

    localparam spi_state_t ST_IDLE    = 3'd0;
    localparam spi_state_t ST_SETUP   = 3'd1;
    localparam spi_state_t ST_HIGH    = 3'd2;
    localparam spi_state_t ST_LOW     = 3'd3;
    localparam spi_state_t ST_WAIT    = 3'd4;
    localparam spi_state_t ST_HOLD    = 3'd5;
    localparam spi_state_t ST_RECOVER = 3'd6;

endpackage

// File: rtl/spi_sck_gen.sv
// Half-period timer: emits a one-cycle phase_tick on the last cycle of every
// HALF_PERIOD-cycle phase while run is high; restart forces the count to zero.
module spi_sck_gen #(
    parameter int HALF_PERIOD = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic run,
    input  logic restart,
    output logic phase_tick
);

    localparam int CNT_W = $clog2(HALF_PERIOD);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(HALF_PERIOD - 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    assign phase_tick = run && (cnt_q == CNT_MAX);

    always_comb begin
        cnt_d = cnt_q;
        if (restart || phase_tick) begin
            cnt_d = '0;
        end else if (run) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/spi_master.sv
// Mode-0 (CPOL=0, CPHA=0), MSB-first byte SPI master with start/ready host
// handshake, optional CS hold across bytes, and a CS-high recovery period.
module spi_master
    import spi_pkg::*;
#(
    parameter int HALF_PERIOD = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [SPI_BYTE_W-1:0] tx_data,
    input  logic                  last,
    output logic                  ready,
    output logic                  busy,
    output logic [SPI_BYTE_W-1:0] rx_data,
    output logic                  rx_valid,
    output logic                  sck,
    output logic                  mosi,
    output logic                  cs,
    input  logic                  miso
);

    generate
        if (HALF_PERIOD < SPI_MIN_HALF_PERIOD) begin : g_bad_half_period
            $error("spi_master: HALF_PERIOD must be >= %0d", SPI_MIN_HALF_PERIOD);
        end
    endgenerate

    localparam logic [2:0] LAST_BIT = 3'(SPI_BYTE_W - 1);

    spi_state_t            state_q, state_d;
    logic                  cs_q, cs_d;
    logic                  sck_q, sck_d;
    logic [SPI_BYTE_W-1:0] tx_sr_q, tx_sr_d;
    logic [SPI_BYTE_W-1:0] rx_sr_q, rx_sr_d;
    logic [SPI_BYTE_W-1:0] rx_data_q, rx_data_d;
    logic                  rx_valid_q, rx_valid_d;
    logic [2:0]            bit_cnt_q, bit_cnt_d;
    logic                  last_q, last_d;
    logic                  run;
    logic                  restart;
    logic                  phase_tick;

    spi_sck_gen #(
        .HALF_PERIOD(HALF_PERIOD)
    ) u_sck_gen (
        .clk       (clk),
        .rst       (rst),
        .run       (run),
        .restart   (restart),
        .phase_tick(phase_tick)
    );

    assign run      = (state_q != ST_IDLE) && (state_q != ST_WAIT);
    assign ready    = (state_q == ST_IDLE) || (state_q == ST_WAIT);
    assign busy     = (state_q != ST_IDLE);
    assign cs       = cs_q;
    assign sck      = sck_q;
    // The TX shift register MSB is the MOSI flop, so MOSI only moves on load or shift.
    assign mosi     = tx_sr_q[SPI_BYTE_W-1];
    assign rx_data  = rx_data_q;
    assign rx_valid = rx_valid_q;

    always_comb begin
        state_d    = state_q;
        cs_d       = cs_q;
        sck_d      = sck_q;
        tx_sr_d    = tx_sr_q;
        rx_sr_d    = rx_sr_q;
        rx_data_d  = rx_data_q;
        rx_valid_d = 1'b0;
        bit_cnt_d  = bit_cnt_q;
        last_d     = last_q;
        restart    = 1'b0;

        case (state_q)
            ST_IDLE, ST_WAIT: begin
                if (start) begin
                    tx_sr_d   = tx_data;
                    last_d    = last;
                    cs_d      = 1'b0;
                    bit_cnt_d = '0;
                    restart   = 1'b1;
                    state_d   = ST_SETUP;
                end
            end
            ST_SETUP, ST_LOW: begin
                if (phase_tick) begin
                    // MISO has been settled since well after the last falling edge.
                    sck_d   = 1'b1;
                    rx_sr_d = {rx_sr_q[SPI_BYTE_W-2:0], miso};
                    state_d = ST_HIGH;
                end
            end
            ST_HIGH: begin
                if (phase_tick) begin
                    sck_d = 1'b0;
                    if (bit_cnt_q != LAST_BIT) begin
                        bit_cnt_d = bit_cnt_q + 1'b1;
                        tx_sr_d   = {tx_sr_q[SPI_BYTE_W-2:0], 1'b0};
                        state_d   = ST_LOW;
                    end else begin
                        rx_data_d  = rx_sr_q;
                        rx_valid_d = 1'b1;
                        restart    = last_q;
                        state_d    = last_q ? ST_HOLD : ST_WAIT;
                    end
                end
            end
            ST_HOLD: begin
                if (phase_tick) begin
                    cs_d    = 1'b1;
                    restart = 1'b1;
                    state_d = ST_RECOVER;
                end
            end
            ST_RECOVER: begin
                if (phase_tick) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                cs_d    = 1'b1;
                sck_d   = 1'b0;
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            cs_q       <= 1'b1;
            sck_q      <= 1'b0;
            tx_sr_q    <= '0;
            rx_sr_q    <= '0;
            rx_data_q  <= '0;
            rx_valid_q <= 1'b0;
            bit_cnt_q  <= '0;
            last_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cs_q       <= cs_d;
            sck_q      <= sck_d;
            tx_sr_q    <= tx_sr_d;
            rx_sr_q    <= rx_sr_d;
            rx_data_q  <= rx_data_d;
            rx_valid_q <= rx_valid_d;
            bit_cnt_q  <= bit_cnt_d;
            last_q     <= last_d;
        end
    end

endmodule
